// File: rtl/accel_pkg.sv
// accel_pkg: constants and types shared by the accelerator command sequencer
// and the control unit it drives.
//   - OP_* values written to the control unit's operation register
//   - STATUS_* values written to the control unit's status register
//   - CMD_* 2-bit host command codes (00/11 are illegal)
//   - seq_state_t: sequencer state encoding (ST_ERR only with SEQ_TIMEOUT_EN)
// Optional feature macro: SEQ_TIMEOUT_EN (adds the watchdog ERR state).
package accel_pkg;

  localparam logic [31:0] OP_IDLE      = 32'h0000_0000;
  localparam logic [31:0] OP_MUL       = 32'h0000_0001;
  localparam logic [31:0] OP_CONV      = 32'h0000_0002;

  localparam logic [31:0] STATUS_START = 32'hFFFF_FFFF;
  localparam logic [31:0] STATUS_CLEAR = 32'h0000_0000;

  localparam logic [1:0]  CMD_MUL      = 2'b01;
  localparam logic [1:0]  CMD_CONV     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_CLEAR = 3'd3
`ifdef SEQ_TIMEOUT_EN
    , ST_ERR = 3'd4
`endif
  } seq_state_t;

  // Only MUL and CONV are ever stored in the queue.
  function automatic logic cmd_is_legal(input logic [1:0] code);
    return (code == CMD_MUL) || (code == CMD_CONV);
  endfunction

  // Map a command code onto the control unit's operation register value.
  function automatic logic [31:0] cmd_to_operation(input logic [1:0] code);
    logic [31:0] op;
    case (code)
      CMD_MUL:  op = OP_MUL;
      CMD_CONV: op = OP_CONV;
      default:  op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/accel_cmd_fifo.sv
// accel_cmd_fifo: DEPTH x 2-bit command queue.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   push, push_data     write request / command code (ignored when full)
//   pop                 read request (ignored when empty)
//   pop_data            head of queue (valid while !empty)
//   full, empty         derived from registered pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module accel_cmd_fifo
  import accel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic [1:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [1:0]  mem_r [DEPTH];
  logic        do_push_s;
  logic        do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer and storage update; push and pop may happen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 2'b00;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/accel_cmd_sequencer.sv
// accel_cmd_sequencer: queues host MUL/CONV commands and runs the
// operation/status/finished handshake with the accelerator control unit.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid, cmd_op       host command offer (01 MUL, 10 CONV, else illegal)
//   cmd_ready               !full; an offer is taken when valid && ready
//   operation, status       registers driven to the control unit
//   finished                handshake response from the control unit
//   busy                    state is not IDLE
//   done_pulse, done_op     one-cycle completion strobe and its command code
//   done_count              wrapping completion counter
//   illegal_pulse           one-cycle strobe for an accepted illegal code
//   err, err_clear          watchdog error / clear (SEQ_TIMEOUT_EN only)
// Optional feature macro: SEQ_TIMEOUT_EN.
module accel_cmd_sequencer
  import accel_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic [31:0]      operation,
  output logic [31:0]      status,
  input  logic             finished,
  output logic             busy,
  output logic             done_pulse,
  output logic [1:0]       done_op,
  output logic [CNT_W-1:0] done_count,
  output logic             illegal_pulse
`ifdef SEQ_TIMEOUT_EN
  , output logic           err,
  input  logic             err_clear
`endif
);

  seq_state_t state_r;
  logic [1:0] cur_op_r;
  logic       accept_s;
  logic       fifo_push_s;
  logic       fifo_pop_s;
  logic [1:0] fifo_head_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;

  assign cmd_ready   = !fifo_full_s;
  assign accept_s    = cmd_valid && cmd_ready;
  // Illegal codes are consumed from the host but never enter the queue.
  assign fifo_push_s = accept_s && cmd_is_legal(cmd_op);
  assign fifo_pop_s  = (state_r == ST_IDLE) && !fifo_empty_s;

  accel_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push_s),
    .push_data (cmd_op),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
  logic [31:0] timer_r;
`else
  logic [31:0] timeout_unused_s;
  assign timeout_unused_s = 32'(TIMEOUT_CYCLES);
`endif

  // Illegal-command strobe, one cycle after the accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_pulse <= 1'b0;
    end else begin
      illegal_pulse <= accept_s && !cmd_is_legal(cmd_op);
    end
  end

  // Handshake state machine; every output it drives is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      operation  <= OP_IDLE;
      status     <= STATUS_CLEAR;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      done_op    <= 2'b00;
      done_count <= '0;
      cur_op_r   <= 2'b00;
`ifdef SEQ_TIMEOUT_EN
      timer_r    <= 32'd0;
      err        <= 1'b0;
`endif
    end else begin
      done_pulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          status <= STATUS_CLEAR;
          if (!fifo_empty_s) begin
            operation <= cmd_to_operation(fifo_head_s);
            cur_op_r  <= fifo_head_s;
            busy      <= 1'b1;
            state_r   <= ST_LOAD;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          // operation has been stable for a full cycle; raise the start strobe.
          status  <= STATUS_START;
          state_r <= ST_START;
`ifdef SEQ_TIMEOUT_EN
          timer_r <= 32'd0;
`endif
        end
        ST_START: begin
          // status drops on the same edge finished is seen, so the control
          // unit never observes start together with finished after this.
          if (finished) begin
            status  <= STATUS_CLEAR;
            state_r <= ST_CLEAR;
`ifdef SEQ_TIMEOUT_EN
            timer_r <= 32'd0;
          end else if (timer_r >= TIMEOUT_LIM) begin
            status    <= STATUS_CLEAR;
            operation <= OP_IDLE;
            err       <= 1'b1;
            state_r   <= ST_ERR;
          end else begin
            timer_r <= timer_r + 32'd1;
`else
          end else begin
            state_r <= ST_START;
`endif
          end
        end
        ST_CLEAR: begin
          status <= STATUS_CLEAR;
          if (!finished) begin
            operation  <= OP_IDLE;
            done_op    <= cur_op_r;
            done_count <= done_count + {{(CNT_W-1){1'b0}}, 1'b1};
            done_pulse <= 1'b1;
            busy       <= 1'b0;
            state_r    <= ST_IDLE;
`ifdef SEQ_TIMEOUT_EN
          end else if (timer_r >= TIMEOUT_LIM) begin
            operation <= OP_IDLE;
            err       <= 1'b1;
            state_r   <= ST_ERR;
          end else begin
            timer_r <= timer_r + 32'd1;
`else
          end else begin
            state_r <= ST_CLEAR;
`endif
          end
        end
`ifdef SEQ_TIMEOUT_EN
        ST_ERR: begin
          // Queue keeps filling but is not popped until err is cleared.
          status    <= STATUS_CLEAR;
          operation <= OP_IDLE;
          if (err_clear) begin
            err     <= 1'b0;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            busy <= 1'b1;
          end
        end
`endif
        default: begin
          state_r   <= ST_IDLE;
          status    <= STATUS_CLEAR;
          operation <= OP_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_cmd_sequencer.sv
// Self-checking bench for accel_cmd_sequencer (default DEPTH=4, CNT_W=16).
// Build with SEQ_TIMEOUT_EN defined to also exercise the watchdog path
// (TIMEOUT_CYCLES=100 in that build).
module tb_accel_cmd_sequencer;
  import accel_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic [31:0] operation;
  logic [31:0] status;
  logic        finished;
  logic        busy;
  logic        done_pulse;
  logic [1:0]  done_op;
  logic [15:0] done_count;
  logic        illegal_pulse;
`ifdef SEQ_TIMEOUT_EN
  logic        err;
  logic        err_clear;
`endif

  int n_cmp;
  int n_fail;
  int exp_count;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] exp_operation;
    logic        illegal;
    int          fin_delay;
  } vec_t;

  vec_t vecs [6];

  accel_cmd_sequencer #(
    .DEPTH          (4),
    .CNT_W          (16),
`ifdef SEQ_TIMEOUT_EN
    .TIMEOUT_CYCLES (100)
`else
    .TIMEOUT_CYCLES (65535)
`endif
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .cmd_ready     (cmd_ready),
    .operation     (operation),
    .status        (status),
    .finished      (finished),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .done_op       (done_op),
    .done_count    (done_count),
    .illegal_pulse (illegal_pulse)
`ifdef SEQ_TIMEOUT_EN
    , .err         (err),
    .err_clear     (err_clear)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_status(input logic [31:0] val, input int limit);
    int n;
    n = 0;
    while (status !== val && n < limit) begin
      tick();
      n++;
    end
    chk("wait_status", status, val);
  endtask

  task automatic push_cmd(input logic [1:0] op);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Plays the control unit for one command already issued or queued.
  task automatic run_one(input logic [1:0] exp_op);
    wait_status(STATUS_START, 200);
    chk("run_operation", operation, cmd_to_operation(exp_op));
    repeat (3) tick();
    finished = 1'b1;
    tick();
    chk("run_status_clear", status, STATUS_CLEAR);
    finished = 1'b0;
    tick();
    exp_count++;
    chk("run_done_pulse", 32'(done_pulse), 32'd1);
    chk("run_done_op", 32'(done_op), 32'(exp_op));
    chk("run_done_count", 32'(done_count), 32'(exp_count));
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    exp_count = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    finished  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    err_clear = 1'b0;
`endif

    vecs[0] = '{2'b01, OP_MUL,  1'b0, 0};
    vecs[1] = '{2'b10, OP_CONV, 1'b0, 3};
    vecs[2] = '{2'b00, OP_IDLE, 1'b1, 0};
    vecs[3] = '{2'b11, OP_IDLE, 1'b1, 0};
    vecs[4] = '{2'b10, OP_CONV, 1'b0, 1};
    vecs[5] = '{2'b01, OP_MUL,  1'b0, 5};

    // Reset values
    #12;
    chk("rst_operation", operation, 32'h0);
    chk("rst_status", status, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_pulse", 32'(done_pulse), 32'd0);
    chk("rst_done_op", 32'(done_op), 32'd0);
    chk("rst_done_count", 32'(done_count), 32'd0);
    chk("rst_illegal", 32'(illegal_pulse), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single MUL timeline with exact cycle offsets
    cmd_valid = 1'b1;
    cmd_op    = CMD_MUL;
    tick();
    cmd_valid = 1'b0;
    chk("tl_n_status", status, STATUS_CLEAR);
    tick();
    chk("tl_n1_operation", operation, OP_MUL);
    chk("tl_n1_status", status, STATUS_CLEAR);
    chk("tl_n1_busy", 32'(busy), 32'd1);
    tick();
    chk("tl_n2_status", status, STATUS_START);
    repeat (12) tick();
    chk("tl_hold_status", status, STATUS_START);
    finished = 1'b1;
    tick();
    chk("tl_m_status", status, STATUS_CLEAR);
    chk("tl_m_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("tl_clear_hold", status, STATUS_CLEAR);
    chk("tl_clear_nodone", 32'(done_pulse), 32'd0);
    finished = 1'b0;
    tick();
    chk("tl_k_done_pulse", 32'(done_pulse), 32'd1);
    chk("tl_k_done_op", 32'(done_op), 32'(CMD_MUL));
    chk("tl_k_done_count", 32'(done_count), 32'd1);
    chk("tl_k_operation", operation, OP_IDLE);
    chk("tl_k_busy", 32'(busy), 32'd0);
    tick();
    chk("tl_pulse_width", 32'(done_pulse), 32'd0);
    exp_count = 1;

    // Table-driven single commands, legal and illegal
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = vecs[i].op;
      tick();
      cmd_valid = 1'b0;
      if (vecs[i].illegal) begin
        chk("vec_illegal_pulse", 32'(illegal_pulse), 32'd1);
        tick();
        chk("vec_illegal_width", 32'(illegal_pulse), 32'd0);
        chk("vec_illegal_busy", 32'(busy), 32'd0);
        chk("vec_illegal_status", status, STATUS_CLEAR);
        chk("vec_illegal_count", 32'(done_count), 32'(exp_count));
      end else begin
        chk("vec_no_illegal", 32'(illegal_pulse), 32'd0);
        tick();
        chk("vec_operation", operation, vecs[i].exp_operation);
        chk("vec_busy", 32'(busy), 32'd1);
        tick();
        chk("vec_status_start", status, STATUS_START);
        repeat (vecs[i].fin_delay) tick();
        finished = 1'b1;
        tick();
        chk("vec_status_clear", status, STATUS_CLEAR);
        finished = 1'b0;
        tick();
        exp_count++;
        chk("vec_done_pulse", 32'(done_pulse), 32'd1);
        chk("vec_done_op", 32'(done_op), 32'(vecs[i].op));
        chk("vec_done_count", 32'(done_count), 32'(exp_count));
        tick();
      end
    end

    // Fill the queue behind a stalled command, then drain in order
    push_cmd(CMD_MUL);
    push_cmd(CMD_CONV);
    push_cmd(CMD_MUL);
    push_cmd(CMD_CONV);
    push_cmd(CMD_MUL);
    chk("fill_cmd_ready_low", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = CMD_CONV;
    repeat (3) tick();
    chk("fill_stall_hold", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    run_one(CMD_MUL);
    run_one(CMD_CONV);
    run_one(CMD_MUL);
    run_one(CMD_CONV);
    run_one(CMD_MUL);
    chk("fill_done_count", 32'(done_count), 32'(exp_count));
    repeat (4) tick();
    chk("fill_drained_busy", 32'(busy), 32'd0);

    // Simultaneous push and pop with one entry queued
    push_cmd(CMD_MUL);
    push_cmd(CMD_CONV);
    run_one(CMD_MUL);
    cmd_valid = 1'b1;
    cmd_op    = CMD_MUL;
    tick();
    cmd_valid = 1'b0;
    chk("pp_operation", operation, OP_CONV);
    chk("pp_cmd_ready", 32'(cmd_ready), 32'd1);
    run_one(CMD_CONV);
    run_one(CMD_MUL);
    repeat (4) tick();
    chk("pp_empty_busy", 32'(busy), 32'd0);

    // Asynchronous reset while in START flushes everything
    push_cmd(CMD_MUL);
    push_cmd(CMD_CONV);
    wait_status(STATUS_START, 50);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_status", status, 32'h0);
    chk("ar_operation", operation, 32'h0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done_count", 32'(done_count), 32'd0);
    chk("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    exp_count = 0;
    repeat (6) tick();
    chk("ar_flushed_busy", 32'(busy), 32'd0);
    chk("ar_flushed_status", status, STATUS_CLEAR);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: control unit never answers
    chk("to_err_init", 32'(err), 32'd0);
    push_cmd(CMD_MUL);
    push_cmd(CMD_CONV);
    wait_status(STATUS_START, 50);
    begin
      int n;
      n = 0;
      while (!err && n < 150) begin
        tick();
        n++;
      end
    end
    chk("to_err_set", 32'(err), 32'd1);
    chk("to_status", status, STATUS_CLEAR);
    chk("to_operation", operation, OP_IDLE);
    chk("to_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    chk("to_err_sticky", 32'(err), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("to_err_cleared", 32'(err), 32'd0);
    run_one(CMD_CONV);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
